// File: rtl/reaction_timer.sv
// Reaction timer: measures ms between lights_out and the first button press.
// Detects jump starts (press before lights_out) and timeouts (no press within MAX_MS).
// The result is held with valid=1 until the consumer acks it.
module reaction_timer #(
    parameter int TICK_DIV = 1000,  // clk cycles per 1 ms tick
    parameter int MAX_MS   = 9999   // saturation / timeout value in ms
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arm,
    input  logic        lights_out,
    input  logic        button,
    input  logic        ack,
    output logic [13:0] result_ms,
    output logic [15:0] result_bcd,
    output logic        valid,
    output logic        jump_start,
    output logic        timeout,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ARMED, TIMING, DONE} state_t;

    localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);
    localparam logic [13:0] MS_LAST    = 14'(MAX_MS - 1);

    state_t      state;
    logic [15:0] presc;
    logic [13:0] ms_cnt;
    logic [15:0] bcd_cnt;
    logic        btn_prev;
    logic        js_q;
    logic        to_q;
    logic        press;
    logic        tick;

    // Add one to a 4-digit BCD value, rippling the carry from the units digit up.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // A press is a rising edge only; a held button never re-triggers.
    assign press = button & ~btn_prev;
    assign tick  = (presc == PRESC_LAST);

    // Round FSM, prescaler and binary/BCD ms counters. The counters stop
    // once DONE is reached, so they double as the held result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            presc    <= '0;
            ms_cnt   <= '0;
            bcd_cnt  <= '0;
            btn_prev <= 1'b0;
            js_q     <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            btn_prev <= button;
            case (state)
                IDLE: begin
                    if (arm) begin
                        state   <= ARMED;
                        presc   <= '0;
                        ms_cnt  <= '0;
                        bcd_cnt <= '0;
                        js_q    <= 1'b0;
                        to_q    <= 1'b0;
                    end
                end
                ARMED: begin
                    // press wins over a coincident lights_out: jump start, result 0
                    if (press) begin
                        state <= DONE;
                        js_q  <= 1'b1;
                    end else if (lights_out) begin
                        state  <= TIMING;
                        presc  <= '0;
                        ms_cnt <= '0;
                    end
                end
                TIMING: begin
                    // a press freezes the count; a wrap in the same cycle is dropped
                    if (press) begin
                        state <= DONE;
                    end else if (tick) begin
                        presc   <= '0;
                        ms_cnt  <= ms_cnt + 14'd1;
                        bcd_cnt <= bcd_inc(bcd_cnt);
                        if (ms_cnt == MS_LAST) begin
                            state <= DONE;
                            to_q  <= 1'b1;
                        end
                    end else begin
                        presc <= presc + 16'd1;
                    end
                end
                DONE: begin
                    if (ack) begin
                        if (arm) begin
                            state   <= ARMED;
                            presc   <= '0;
                            ms_cnt  <= '0;
                            bcd_cnt <= '0;
                            js_q    <= 1'b0;
                            to_q    <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Moore outputs: decoded from the state register and held counters only.
    assign result_ms  = ms_cnt;
    assign result_bcd = bcd_cnt;
    assign jump_start = js_q;
    assign timeout    = to_q;
    assign valid      = (state == DONE);
    assign busy       = (state == ARMED) || (state == TIMING);

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer. Instance a uses TICK_DIV=4, MAX_MS=20;
// instance b uses TICK_DIV=2, MAX_MS=9999 for the BCD carry cases.
module tb_reaction_timer;

    logic        clk;
    logic        rst;
    logic        arm_a, lo_a, btn_a, ack_a;
    logic [13:0] ms_a;
    logic [15:0] bcd_a;
    logic        valid_a, js_a, to_a, busy_a;
    logic        arm_b, lo_b, btn_b, ack_b;
    logic [13:0] ms_b;
    logic [15:0] bcd_b;
    logic        valid_b, js_b, to_b, busy_b;

    int n_tests = 0;
    int n_fail  = 0;

    reaction_timer #(.TICK_DIV(4), .MAX_MS(20)) dut_a (
        .clk(clk), .rst(rst), .arm(arm_a), .lights_out(lo_a), .button(btn_a), .ack(ack_a),
        .result_ms(ms_a), .result_bcd(bcd_a), .valid(valid_a), .jump_start(js_a),
        .timeout(to_a), .busy(busy_a)
    );

    reaction_timer #(.TICK_DIV(2), .MAX_MS(9999)) dut_b (
        .clk(clk), .rst(rst), .arm(arm_b), .lights_out(lo_b), .button(btn_b), .ack(ack_b),
        .result_ms(ms_b), .result_bcd(bcd_b), .valid(valid_b), .jump_start(js_b),
        .timeout(to_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input bit a, input bit l, input bit k);
        arm_a = a; lo_a = l; ack_a = k;
        step(1);
        arm_a = 1'b0; lo_a = 1'b0; ack_a = 1'b0;
    endtask

    task automatic check_a(input string tag, input bit v, input bit j, input bit t,
                           input bit b, input logic [13:0] ms, input logic [15:0] bcd);
        check({tag, ".valid"}, 32'(valid_a), 32'(v));
        check({tag, ".js"},    32'(js_a),    32'(j));
        check({tag, ".to"},    32'(to_a),    32'(t));
        check({tag, ".busy"},  32'(busy_a),  32'(b));
        check({tag, ".ms"},    32'(ms_a),    32'(ms));
        check({tag, ".bcd"},   32'(bcd_a),   32'(bcd));
    endtask

    // Round on instance b: press after n TIMING cycles, expect ms/bcd, then ack.
    task automatic round_b(input string tag, input int n, input logic [13:0] ms,
                           input logic [15:0] bcd);
        arm_b = 1'b1; step(1); arm_b = 1'b0;
        lo_b = 1'b1;  step(1); lo_b = 1'b0;
        step(n);
        btn_b = 1'b1; step(1);
        check({tag, ".valid"}, 32'(valid_b), 32'd1);
        check({tag, ".ms"},    32'(ms_b),    32'(ms));
        check({tag, ".bcd"},   32'(bcd_b),   32'(bcd));
        check({tag, ".flags"}, 32'({js_b, to_b}), 32'd0);
        btn_b = 1'b0; ack_b = 1'b1; step(1); ack_b = 1'b0;
        check({tag, ".idle"},  32'(valid_b), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        arm_a = 0; lo_a = 0; btn_a = 0; ack_a = 0;
        arm_b = 0; lo_b = 0; btn_b = 0; ack_b = 0;
        #1;
        check_a("rst", 0, 0, 0, 0, 14'd0, 16'h0000);
        step(2);
        rst = 1'b0;
        step(3);
        check_a("post_rst", 0, 0, 0, 0, 14'd0, 16'h0000);

        // Normal round: 50 TIMING cycles with TICK_DIV=4 -> 12 ms
        pulse_a(1, 0, 0);
        check_a("armed", 0, 0, 0, 1, 14'd0, 16'h0000);
        step(9);
        pulse_a(0, 1, 0);
        check("timing.busy", 32'(busy_a), 32'd1);
        step(50);
        check("timing.ms50", 32'(ms_a), 32'd12);
        btn_a = 1'b1; step(1);
        check_a("normal", 1, 0, 0, 0, 14'd12, 16'h0012);

        // Held result: presses and lights_out ignored for 20 cycles without ack
        for (int i = 0; i < 20; i++) begin
            btn_a = (i % 2 == 1);
            lo_a  = (i % 5 == 0);
            step(1);
            check("hold.ms",  32'({valid_a, ms_a}),  32'({1'b1, 14'd12}));
            check("hold.bcd", 32'(bcd_a), 32'h0012);
        end
        btn_a = 1'b0; lo_a = 1'b0;
        pulse_a(0, 0, 1);
        check_a("ack", 0, 0, 0, 0, 14'd12, 16'h0012);

        // Jump start: press before lights_out
        pulse_a(1, 0, 0);
        step(2);
        btn_a = 1'b1; step(1);
        check_a("js_early", 1, 1, 0, 0, 14'd0, 16'h0000);
        btn_a = 1'b0;
        pulse_a(0, 0, 1);

        // Jump start: press coincident with lights_out
        pulse_a(1, 0, 0);
        step(2);
        btn_a = 1'b1; pulse_a(0, 1, 0);
        check_a("js_coinc", 1, 1, 0, 0, 14'd0, 16'h0000);
        btn_a = 1'b0;

        // ack+arm together: straight to ARMED with flags cleared
        pulse_a(1, 0, 1);
        check_a("ack_arm", 0, 0, 0, 1, 14'd0, 16'h0000);

        // Timeout: 79 TIMING cycles still counting, the 80th saturates at 20
        pulse_a(0, 1, 0);
        step(79);
        check_a("pre_to", 0, 0, 0, 1, 14'd19, 16'h0019);
        step(1);
        check_a("timeout", 1, 0, 1, 0, 14'd20, 16'h0020);
        pulse_a(0, 0, 1);
        check("to_ack.valid", 32'(valid_a), 32'd0);

        // Button held from before arm never counts as a press
        btn_a = 1'b1; step(2);
        pulse_a(1, 0, 0);
        pulse_a(0, 1, 0);
        step(80);
        check_a("held_btn", 1, 0, 1, 0, 14'd20, 16'h0020);
        btn_a = 1'b0;
        pulse_a(0, 0, 1);

        // Reset mid-TIMING abandons the round immediately
        pulse_a(1, 0, 0);
        pulse_a(0, 1, 0);
        step(10);
        check("mid.ms", 32'(ms_a), 32'd2);
        rst = 1'b1; #1;
        check_a("rst_mid", 0, 0, 0, 0, 14'd0, 16'h0000);
        step(1);
        rst = 1'b0;
        step(1);
        pulse_a(0, 1, 0);
        step(10);
        check_a("lo_idle", 0, 0, 0, 0, 14'd0, 16'h0000);

        // BCD carries on instance b (TICK_DIV=2)
        round_b("b9",    19,   14'd9,    16'h0009);
        round_b("b10",   20,   14'd10,   16'h0010);
        round_b("b1099", 2198, 14'd1099, 16'h1099);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
